lcd_12864b_rx: RTL

//  Bus-side responder for the 12864B (ST7920-style) 8-bit parallel LCD interface: the LCD end of the bus.

---
 rtl/lcd_12864b_rx.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_12864b_rx.sv
// ---------------------------------------------------------------------------
// lcd_12864b_rx
//   LCD-side responder for a 12864B / ST7920-style 8-bit parallel bus. It
//   stands in for a physical panel. Every write cycle ({rs,data}) is captured
//   into a first-word-fall-through FIFO. Read cycles get status back: the
//   busy flag and the 7-bit address counter (AC), or the last data byte.
//
// Optional feature macro: LCD_RX_BUSY_CHK_EN
//   Defined   : a write captured while busy is high sets sticky busy_viol.
//   Undefined : no checking logic is built and busy_viol is tied low.
//
// Parameters
//   N        FIFO depth in entries (power of 2, >= 2)
//   BUSY_CYC busy duration in clk cycles after each captured write (>= 1)
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   rs, rw, e         bus control from the LCD writer (asynchronous to clk)
//   lcd_data          bus data from the writer
//   lcd_q, lcd_oe     read data returned to the bus, and its output enable
//   pop               consume the FIFO head (ignored when empty)
//   out_data, out_rs  FIFO head, valid while !empty
//   qcount            number of entries held, 0..N
//   empty, full       FIFO status
//   overflow          sticky: a write was dropped because the FIFO was full
//   busy              emulated busy flag
//   busy_viol         sticky: a write was captured while busy
// ---------------------------------------------------------------------------
module lcd_12864b_rx #(
  parameter int N        = 8,
  parameter int BUSY_CYC = 72
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs,
  input  logic                 rw,
  input  logic                 e,
  input  logic [7:0]           lcd_data,
  output logic [7:0]           lcd_q,
  output logic                 lcd_oe,
  input  logic                 pop,
  output logic [7:0]           out_data,
  output logic                 out_rs,
  output logic [$clog2(N):0]   qcount,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 busy,
  output logic                 busy_viol
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(BUSY_CYC + 1);

  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(N);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYC);
  localparam logic [CW-1:0] BUSY_ONE = CW'(1);

  // -------------------------------------------------------------------------
  // Input synchronizer. The whole bus is carried as one group
  // {rs, rw, e, data}, so the fields seen downstream always belong together.
  // -------------------------------------------------------------------------
  logic [10:0] sync1_q;
  logic [10:0] sync2_q;
  logic        e_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      e_dly_q <= 1'b0;
    end else begin
      sync1_q <= {rs, rw, e, lcd_data};
      sync2_q <= sync1_q;
      e_dly_q <= sync2_q[8];
    end
  end

  logic       s_rs;
  logic       s_rw;
  logic       s_e;
  logic [7:0] s_data;
  logic       e_rise;
  logic       e_fall;

  assign s_rs   = sync2_q[10];
  assign s_rw   = sync2_q[9];
  assign s_e    = sync2_q[8];
  assign s_data = sync2_q[7:0];
  assign e_rise = s_e & ~e_dly_q;
  assign e_fall = ~s_e & e_dly_q;

  // -------------------------------------------------------------------------
  // Bus-cycle FSM. Direction is latched at the rising edge of e. The write
  // payload is taken at the falling edge, when the writer's data is settled.
  // -------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    E_HI = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   rw_lat_q, rw_lat_d;
  logic   wr_capture;
  logic   rd_start;
  logic   rd_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rw_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_lat_q <= rw_lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_lat_d   = rw_lat_q;
    wr_capture = 1'b0;
    rd_start   = 1'b0;
    rd_end     = 1'b0;
    case (state_q)
      IDLE: begin
        if (e_rise) begin
          state_d  = E_HI;
          rw_lat_d = s_rw;
          rd_start = s_rw;
        end
      end
      E_HI: begin
        if (e_fall) begin
          state_d = IDLE;
          if (rw_lat_q) begin
            rd_end = 1'b1;
          end else begin
            wr_capture = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address counter, last data byte and busy emulation
  // -------------------------------------------------------------------------
  logic [6:0]    ac_q, ac_d;
  logic [7:0]    last_data_q, last_data_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          busy_q;

  always_comb begin
    ac_d        = ac_q;
    last_data_d = last_data_q;
    if (wr_capture) begin
      if (s_rs) begin
        // A data write auto-increments AC. The 7-bit add wraps 0x7F to 0x00.
        ac_d        = ac_q + 7'd1;
        last_data_d = s_data;
      end else if (s_data[7]) begin
        ac_d = s_data[6:0];           // set DDRAM address
      end else if (s_data == 8'h01) begin
        ac_d = 7'd0;                  // clear display homes AC
      end
    end
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (wr_capture) begin
      busy_cnt_d = BUSY_LD;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BUSY_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q        <= 7'd0;
      last_data_q <= 8'h00;
      busy_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ac_q        <= ac_d;
      last_data_q <= last_data_d;
      busy_cnt_q  <= busy_cnt_d;
      // busy mirrors the next counter value so it is set in the same cycle
      // as the load and drops in the cycle the counter reaches zero.
      busy_q      <= (busy_cnt_d != '0);
    end
  end

  assign busy = busy_q;

  // -------------------------------------------------------------------------
  // Read response. The value is chosen once at the rising edge and held for
  // the whole pulse, so the reader never sees it change mid-strobe.
  // -------------------------------------------------------------------------
  logic [7:0] lcd_q_q, lcd_q_d;
  logic       lcd_oe_q, lcd_oe_d;

  always_comb begin
    lcd_q_d  = lcd_q_q;
    lcd_oe_d = lcd_oe_q;
    if (rd_start) begin
      lcd_oe_d = 1'b1;
      lcd_q_d  = s_rs ? last_data_q : {busy_q, ac_q};
    end else if (rd_end) begin
      lcd_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_q_q  <= 8'h00;
      lcd_oe_q <= 1'b0;
    end else begin
      lcd_q_q  <= lcd_q_d;
      lcd_oe_q <= lcd_oe_d;
    end
  end

  assign lcd_q  = lcd_q_q;
  assign lcd_oe = lcd_oe_q;

  // -------------------------------------------------------------------------
  // FWFT FIFO of {rs, data}
  // -------------------------------------------------------------------------
  logic [8:0]    mem [N];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = pop & ~empty;
  // When full, a pop in the same cycle frees the slot the push needs.
  assign push_ok = wr_capture & (~full | pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_capture & ~push_ok);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {s_rs, s_data};
    end
  end

  assign {out_rs, out_data} = mem[rd_ptr_q];
  assign qcount   = count_q;
  assign overflow = overflow_q;

  // -------------------------------------------------------------------------
  // Optional protocol check: a write arriving while the panel is busy
  // -------------------------------------------------------------------------
`ifdef LCD_RX_BUSY_CHK_EN
  logic busy_viol_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_viol_q <= 1'b0;
    end else if (wr_capture && busy_q) begin
      busy_viol_q <= 1'b1;
    end
  end

  assign busy_viol = busy_viol_q;
`else
  assign busy_viol = 1'b0;
`endif

endmodule
